// File: rtl/tpu_pkg.sv
// Shared TPU definitions: instruction layout, opcodes and sequencer states.
// Field helpers keep every consumer slicing instructions identically.
package tpu_pkg;

  localparam int INSTR_W   = 16;
  localparam int OPC_W     = 3;
  localparam int OPERAND_W = INSTR_W - OPC_W;
  localparam int TIMER_W   = 8;

  typedef enum logic [OPC_W-1:0] {
    OP_HALT        = 3'd0,
    OP_LOAD_ADDR   = 3'd1,
    OP_LOAD_WEIGHT = 3'd2,
    OP_LOAD_INPUT  = 3'd3,
    OP_COMPUTE     = 3'd4,
    OP_STORE       = 3'd5
  } opcode_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_COMPUTE,
    S_DONE,
    S_ERROR
  } seq_state_e;

  function automatic logic [OPC_W-1:0] get_opcode(input logic [INSTR_W-1:0] instr);
    return instr[INSTR_W-1 -: OPC_W];
  endfunction

  function automatic logic [OPERAND_W-1:0] get_operand(input logic [INSTR_W-1:0] instr);
    return instr[OPERAND_W-1:0];
  endfunction

endpackage

// File: rtl/tpu_sequencer.sv
// Instruction sequencer: fetches from a synchronous imem, decodes and drives
// the datapath strobes, owning pc, base address and the COMPUTE hold timer.
module tpu_sequencer
  import tpu_pkg::*;
#(
  parameter int IMEM_DEPTH     = 8,
  parameter int COMPUTE_CYCLES = 6,
  parameter int ADDR_W         = 13,
  localparam int PC_W          = $clog2(IMEM_DEPTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               hold,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [ADDR_W-1:0]  base_address,
  output logic               load_weight,
  output logic               load_input,
  output logic               valid,
  output logic               store,
  output logic               busy,
  output logic               done,
  output logic               error
);

  seq_state_e         state_reg, state_next;
  logic [PC_W-1:0]    pc_reg, pc_next;
  logic [INSTR_W-1:0] ir_reg, ir_next;
  logic [TIMER_W-1:0] timer_reg, timer_next;
  logic [ADDR_W-1:0]  base_reg, base_next;
  logic [OPC_W-1:0]   exec_op;
  logic               last_pc;
  logic               advance;

  assign exec_op = get_opcode(ir_reg);
  assign last_pc = (pc_reg == PC_W'(IMEM_DEPTH - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= S_IDLE;
      pc_reg    <= '0;
      ir_reg    <= '0;
      timer_reg <= '0;
      base_reg  <= '0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      ir_reg    <= ir_next;
      timer_reg <= timer_next;
      base_reg  <= base_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    ir_next    = ir_reg;
    timer_next = timer_reg;
    base_next  = base_reg;
    advance    = 1'b0;

    case (state_reg)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_next = S_FETCH;
          pc_next    = '0;
        end
      end
      S_FETCH: begin
        if (!hold) state_next = S_DECODE;
      end
      S_DECODE: begin
        if (!hold) begin
          ir_next = imem_data;
          if (get_opcode(imem_data) == OP_COMPUTE) begin
            state_next = S_COMPUTE;
            timer_next = TIMER_W'(COMPUTE_CYCLES);
          end else begin
            state_next = S_EXEC;
          end
        end
      end
      S_EXEC: begin
        if (!hold) begin
          case (exec_op)
            OP_HALT:      state_next = S_DONE;
            OP_LOAD_ADDR: begin
              base_next = ADDR_W'(get_operand(ir_reg));
              advance   = 1'b1;
            end
            OP_LOAD_WEIGHT, OP_LOAD_INPUT, OP_STORE, OP_COMPUTE: advance = 1'b1;
            default:      state_next = S_ERROR;
          endcase
        end
      end
      S_COMPUTE: begin
        if (!hold) begin
          if (timer_reg <= TIMER_W'(1)) begin
            timer_next = '0;
            advance    = 1'b1;
          end else begin
            timer_next = timer_reg - TIMER_W'(1);
          end
        end
      end
      default: state_next = S_IDLE;
    endcase

    // A program running off the end of imem is a fault, never a wrap to 0.
    if (advance) begin
      if (last_pc) begin
        state_next = S_ERROR;
      end else begin
        pc_next    = pc_reg + PC_W'(1);
        state_next = S_FETCH;
      end
    end
  end

  // Strobes decode only the state and ir flops; hold masks them so a stalled
  // EXEC issues its strobe exactly once, on the cycle it actually retires.
  always_comb begin
    load_weight = 1'b0;
    load_input  = 1'b0;
    store       = 1'b0;
    valid       = 1'b0;
    if (!hold) begin
      if (state_reg == S_EXEC) begin
        load_weight = (exec_op == OP_LOAD_WEIGHT);
        load_input  = (exec_op == OP_LOAD_INPUT);
        store       = (exec_op == OP_STORE);
      end
      valid = (state_reg == S_COMPUTE);
    end
  end

  assign busy         = (state_reg == S_FETCH) || (state_reg == S_DECODE) ||
                        (state_reg == S_EXEC)  || (state_reg == S_COMPUTE);
  assign done         = (state_reg == S_DONE);
  assign error        = (state_reg == S_ERROR);
  assign imem_addr    = pc_reg;
  assign base_address = base_reg;

endmodule

// File: tb/tb_tpu_sequencer.sv
// Scenario bench for tpu_sequencer: strobe events are scoreboarded against a
// queue of expected {kind, base_address}; timing and hold behaviour checked inline.
module tb_tpu_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        hold = 1'b0;
  logic [2:0]  imem_addr;
  logic [15:0] imem_data = '0;
  logic [12:0] base_address;
  logic        load_weight, load_input, valid, store, busy, done, error;

  logic        start4 = 1'b0;
  logic        hold4 = 1'b0;
  logic [1:0]  imem_addr4;
  logic [15:0] imem_data4 = '0;
  logic [12:0] base4;
  logic        load_weight4, load_input4, valid4, store4, busy4, done4, error4;

  logic [15:0] imem [8];
  logic [15:0] mem4 [4];

  typedef struct {
    int          kind;
    logic [12:0] base;
  } sb_t;
  sb_t exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  always @(posedge clk) imem_data  <= imem[imem_addr];
  always @(posedge clk) imem_data4 <= mem4[imem_addr4];

  tpu_sequencer #(.IMEM_DEPTH(8), .COMPUTE_CYCLES(6), .ADDR_W(13)) dut (
    .clk(clk), .reset(reset), .start(start), .hold(hold),
    .imem_addr(imem_addr), .imem_data(imem_data), .base_address(base_address),
    .load_weight(load_weight), .load_input(load_input), .valid(valid),
    .store(store), .busy(busy), .done(done), .error(error)
  );

  tpu_sequencer #(.IMEM_DEPTH(4), .COMPUTE_CYCLES(6), .ADDR_W(13)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .hold(hold4),
    .imem_addr(imem_addr4), .imem_data(imem_data4), .base_address(base4),
    .load_weight(load_weight4), .load_input(load_input4), .valid(valid4),
    .store(store4), .busy(busy4), .done(done4), .error(error4)
  );

  task automatic pulse_start();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Cycle k=0 is the FETCH cycle entered by the preceding start edge.
  task automatic run_program(input int budget, input int hold_after, input int hold_len,
                             output int end_cyc, output int valid_total, output int run_max,
                             output int valid_in_hold, output int pc_moved);
    int run = 0;
    int pend = 0;
    bit hold_used = 1'b0;
    logic [2:0] pc_hold = '0;
    int nstb;
    int kind;
    sb_t e;
    end_cyc = -1; valid_total = 0; run_max = 0; valid_in_hold = 0; pc_moved = 0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      nstb = int'(load_weight) + int'(load_input) + int'(store);
      if (nstb != 0) begin
        kind = load_weight ? 0 : (load_input ? 1 : 2);
        n_checks++;
        if (nstb != 1 || exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL strobe_event: cycle %0d got kind=%0d strobes=%0d base=%h, expected queue size=%0d",
                   k, kind, nstb, base_address, exp_q.size());
        end else begin
          e = exp_q.pop_front();
          if (e.kind !== kind || e.base !== base_address) begin
            n_fail++;
            $display("FAIL strobe_event: cycle %0d got kind=%0d base=%h, expected kind=%0d base=%h",
                     k, kind, base_address, e.kind, e.base);
          end
        end
      end
      if (valid) begin
        valid_total++;
        run++;
        if (run > run_max) run_max = run;
      end else begin
        run = 0;
      end
      if (hold) begin
        if (valid) valid_in_hold++;
        if (imem_addr !== pc_hold) pc_moved++;
      end
      if (done || error) begin
        end_cyc = k;
        break;
      end
      if (hold_after >= 0 && !hold_used && valid_total == hold_after) begin
        pend = hold_len;
        hold_used = 1'b1;
      end
      @(posedge clk); #1;
      if (pend > 0) begin
        if (!hold) pc_hold = imem_addr;
        hold = 1'b1;
        pend--;
      end else begin
        hold = 1'b0;
      end
    end
    hold = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({load_weight, load_input, valid, store, busy, done, error} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b expected 0000000",
               {load_weight, load_input, valid, store, busy, done, error});
    end
    n_checks++;
    if (imem_addr !== 3'd0 || base_address !== 13'd0) begin
      n_fail++;
      $display("FAIL reset_regs: got addr=%0d base=%h expected 0/0", imem_addr, base_address);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || imem_addr !== 3'd0) begin
      n_fail++;
      $display("FAIL idle_after_reset: got busy=%b done=%b addr=%0d expected 0/0/0", busy, done, imem_addr);
    end
  endtask

  task automatic test_single();
    int ec, vt, rm, vh, pm;
    imem = '{16'h200F, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    pulse_start();
    n_checks++;
    if (busy !== 1'b1 || imem_addr !== 3'd0) begin
      n_fail++;
      $display("FAIL single_fetch: got busy=%b addr=%0d expected 1/0", busy, imem_addr);
    end
    run_program(40, -1, 0, ec, vt, rm, vh, pm);
    n_checks++;
    if (ec !== 6) begin
      n_fail++;
      $display("FAIL single_done_cycle: got %0d expected 6", ec);
    end
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0 || error !== 1'b0) begin
      n_fail++;
      $display("FAIL single_flags: got done=%b busy=%b error=%b expected 1/0/0", done, busy, error);
    end
    n_checks++;
    if (base_address !== 13'h000F || imem_addr !== 3'd1) begin
      n_fail++;
      $display("FAIL single_regs: got base=%h pc=%0d expected 000f/1", base_address, imem_addr);
    end
  endtask

  task automatic test_hold_start();
    int ec, vt, rm, vh, pm;
    imem = '{16'h4000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    exp_q.push_back('{0, 13'h000F});
    @(posedge clk); #1;
    start = 1'b1;
    hold  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b1 || done !== 1'b0 || imem_addr !== 3'd0 || base_address !== 13'h000F ||
          load_weight !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_in_fetch: cycle %0d got busy=%b done=%b addr=%0d base=%h lw=%b expected 1/0/0/000f/0",
                 i, busy, done, imem_addr, base_address, load_weight);
      end
      @(posedge clk); #1;
    end
    hold = 1'b0;
    run_program(40, -1, 0, ec, vt, rm, vh, pm);
    n_checks++;
    if (ec !== 6 || done !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_start_done: got cycle=%0d done=%b expected 6/1", ec, done);
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL hold_start_events: got %0d missing strobes expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_program();
    int ec, vt, rm, vh, pm;
    imem = '{16'h200F, 16'h4000, 16'h201E, 16'h6000, 16'h8000, 16'h2007, 16'hA000, 16'h0000};
    exp_q.push_back('{0, 13'h000F});
    exp_q.push_back('{1, 13'h001E});
    exp_q.push_back('{2, 13'h0007});
    pulse_start();
    run_program(80, -1, 0, ec, vt, rm, vh, pm);
    n_checks++;
    if (ec !== 29) begin
      n_fail++;
      $display("FAIL program_done_cycle: got %0d expected 29", ec);
    end
    n_checks++;
    if (vt !== 6 || rm !== 6) begin
      n_fail++;
      $display("FAIL program_valid: got total=%0d run=%0d expected 6/6", vt, rm);
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL program_events: got %0d missing strobes expected 0", exp_q.size());
      exp_q.delete();
    end
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0 || imem_addr !== 3'd7) begin
      n_fail++;
      $display("FAIL program_end: got done=%b busy=%b pc=%0d expected 1/0/7", done, busy, imem_addr);
    end
  endtask

  task automatic test_illegal();
    int ec, vt, rm, vh, pm;
    imem = '{16'h200F, 16'h4000, 16'hC000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    for (int r = 0; r < 2; r++) begin
      exp_q.push_back('{0, 13'h000F});
      pulse_start();
      n_checks++;
      if (error !== 1'b0 || busy !== 1'b1 || imem_addr !== 3'd0) begin
        n_fail++;
        $display("FAIL illegal_restart: run %0d got error=%b busy=%b pc=%0d expected 0/1/0",
                 r, error, busy, imem_addr);
      end
      run_program(40, -1, 0, ec, vt, rm, vh, pm);
      n_checks++;
      if (ec !== 9 || error !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
        n_fail++;
        $display("FAIL illegal_error: run %0d got cycle=%0d error=%b busy=%b done=%b expected 9/1/0/0",
                 r, ec, error, busy, done);
      end
      n_checks++;
      if (exp_q.size() != 0) begin
        n_fail++;
        $display("FAIL illegal_events: run %0d got %0d missing strobes expected 0", r, exp_q.size());
        exp_q.delete();
      end
    end
  endtask

  task automatic test_compute_hold();
    int ec, vt, rm, vh, pm;
    imem = '{16'h8000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    pulse_start();
    run_program(60, 2, 3, ec, vt, rm, vh, pm);
    n_checks++;
    if (vt !== 6) begin
      n_fail++;
      $display("FAIL hold_valid_total: got %0d expected 6", vt);
    end
    n_checks++;
    if (vh !== 0 || pm !== 0) begin
      n_fail++;
      $display("FAIL hold_frozen: got valid_in_hold=%0d pc_moves=%0d expected 0/0", vh, pm);
    end
    n_checks++;
    if (ec !== 14 || done !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_done_cycle: got cycle=%0d done=%b expected 14/1", ec, done);
    end
  endtask

  task automatic test_overflow();
    int cnt = 0;
    int bad = 0;
    int ec = -1;
    mem4 = '{16'h4000, 16'h4000, 16'h4000, 16'h4000};
    @(posedge clk); #1;
    start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (load_weight4) cnt++;
      if (load_input4 || store4 || valid4 || done4) bad++;
      if (error4) begin
        ec = k;
        break;
      end
      @(posedge clk); #1;
    end
    n_checks++;
    if (cnt !== 4 || ec !== 12) begin
      n_fail++;
      $display("FAIL overflow_pulses: got pulses=%0d error_cycle=%0d expected 4/12", cnt, ec);
    end
    n_checks++;
    if (busy4 !== 1'b0 || done4 !== 1'b0 || imem_addr4 !== 2'd3 || base4 !== 13'd0 || bad !== 0) begin
      n_fail++;
      $display("FAIL overflow_state: got busy=%b done=%b pc=%0d base=%h stray=%0d expected 0/0/3/0000/0",
               busy4, done4, imem_addr4, base4, bad);
    end
  endtask

  task automatic test_reset_mid_compute();
    int ec, vt, rm, vh, pm;
    int vc = 0;
    bit hit = 1'b0;
    imem = '{16'h2005, 16'h8000, 16'h4000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    pulse_start();
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (valid) vc++;
      if (vc == 2) begin
        hit = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    #1 reset = 1'b1;
    #1;
    n_checks++;
    if (hit !== 1'b1 || {load_weight, load_input, valid, store, busy, done, error} !== 7'b0) begin
      n_fail++;
      $display("FAIL async_reset_flags: got reached=%b flags=%b expected 1/0000000", hit,
               {load_weight, load_input, valid, store, busy, done, error});
    end
    n_checks++;
    if (base_address !== 13'd0 || imem_addr !== 3'd0) begin
      n_fail++;
      $display("FAIL async_reset_regs: got base=%h pc=%0d expected 0000/0", base_address, imem_addr);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    imem = '{16'h4000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    exp_q.push_back('{0, 13'h0000});
    pulse_start();
    n_checks++;
    if (imem_addr !== 3'd0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL rerun_fetch: got pc=%0d busy=%b expected 0/1", imem_addr, busy);
    end
    run_program(40, -1, 0, ec, vt, rm, vh, pm);
    n_checks++;
    if (ec !== 6 || done !== 1'b1 || vt !== 0) begin
      n_fail++;
      $display("FAIL rerun_done: got cycle=%0d done=%b valid=%0d expected 6/1/0", ec, done, vt);
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL rerun_events: got %0d missing strobes expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) imem[i] = '0;
    for (int i = 0; i < 4; i++) mem4[i] = '0;
    test_reset();
    test_single();
    test_hold_start();
    test_program();
    test_illegal();
    test_compute_hold();
    test_overflow();
    test_reset_mid_compute();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1);
  end

endmodule
